// File: rtl/bus_pkg.sv
// Shared types for the inter-core instruction bus: instruction codes, core status,
// arbiter FSM states and packed-field helpers for the default 4-core bus.
package bus_pkg;

  localparam int BUS_NUM_CORES     = 4;
  localparam int BUS_CORE_ID_WIDTH = $clog2(BUS_NUM_CORES);
  localparam int BUS_INSTR_WIDTH   = 2;

  typedef enum logic [BUS_INSTR_WIDTH-1:0] {
    HALT_PAUSE = 2'b00,
    STOP       = 2'b01,
    CONTINUE   = 2'b10,
    DONE       = 2'b11
  } bus_instruction_t;

  typedef struct packed {
    logic                         sending;
    logic                         broadcast;
    logic [BUS_CORE_ID_WIDTH-1:0] dst_id;
    bus_instruction_t             instr;
  } core_status_t;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    DELIVER = 2'd1,
    RECOVER = 2'd2
  } bus_arb_state_t;

  function automatic logic [BUS_CORE_ID_WIDTH-1:0] get_dst_id(
    input logic [BUS_NUM_CORES*BUS_CORE_ID_WIDTH-1:0] dst_ids,
    input logic [BUS_CORE_ID_WIDTH-1:0]               core
  );
    return dst_ids[core*BUS_CORE_ID_WIDTH +: BUS_CORE_ID_WIDTH];
  endfunction

  function automatic logic [BUS_INSTR_WIDTH-1:0] get_instruction(
    input logic [BUS_NUM_CORES*BUS_INSTR_WIDTH-1:0] instructions,
    input logic [BUS_CORE_ID_WIDTH-1:0]             core
  );
    return instructions[core*BUS_INSTR_WIDTH +: BUS_INSTR_WIDTH];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1,
// wrapping modulo N.
module rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt_onehot,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  always_comb begin
    logic [IDW-1:0] idx;
    idx        = '0;
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    // Offset N wraps back to ptr itself, so the last winner is checked last.
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_id          = idx;
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_bus_arbiter.sv
// Server side of the inter-core instruction bus: round-robin arbitration, then a
// registered grant/delivery cycle and a recovery cycle per transaction.
module instr_bus_arbiter
  import bus_pkg::*;
#(
  parameter  int NUM_CORES     = 4,
  parameter  int INSTR_WIDTH   = 2,
  localparam int CORE_ID_WIDTH = $clog2(NUM_CORES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CORES-1:0]               send_req,
  input  logic [NUM_CORES-1:0]               broadcast_mode,
  input  logic [NUM_CORES*CORE_ID_WIDTH-1:0] dst_ids,
  input  logic [NUM_CORES*INSTR_WIDTH-1:0]   instructions,
  output logic [NUM_CORES-1:0]               send_grant,
  output logic [NUM_CORES-1:0]               recv_valid,
  output logic [CORE_ID_WIDTH-1:0]           src_id,
  output logic [INSTR_WIDTH-1:0]             instruction,
  output logic                               busy,
  output logic                               drop_err
);

  bus_arb_state_t state_q, state_d;
  logic [CORE_ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_CORES-1:0]     send_grant_q, send_grant_d;
  logic [NUM_CORES-1:0]     recv_valid_q, recv_valid_d;
  logic [CORE_ID_WIDTH-1:0] src_id_q, src_id_d;
  logic [INSTR_WIDTH-1:0]   instruction_q, instruction_d;
  logic                     busy_q, busy_d;
  logic                     drop_err_q, drop_err_d;

  logic [NUM_CORES-1:0]     arb_gnt;
  logic [CORE_ID_WIDTH-1:0] arb_id;
  logic                     arb_any;

  logic [CORE_ID_WIDTH-1:0] dst_arr   [NUM_CORES];
  logic [INSTR_WIDTH-1:0]   instr_arr [NUM_CORES];
  logic [CORE_ID_WIDTH-1:0] win_dst;
  logic [INSTR_WIDTH-1:0]   win_instr;
  logic                     win_bcast;
  logic                     win_dst_ok;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slice
      assign dst_arr[gi]   = dst_ids[gi*CORE_ID_WIDTH +: CORE_ID_WIDTH];
      assign instr_arr[gi] = instructions[gi*INSTR_WIDTH +: INSTR_WIDTH];
    end
  endgenerate

  rr_arbiter #(.N(NUM_CORES)) u_rr (
    .req        (send_req),
    .ptr        (ptr_q),
    .gnt_onehot (arb_gnt),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  assign win_dst    = dst_arr[arb_id];
  assign win_instr  = instr_arr[arb_id];
  assign win_bcast  = broadcast_mode[arb_id];
  assign win_dst_ok = (int'(win_dst) < NUM_CORES) && (win_dst != arb_id);

  // The output registers double as the latched winner fields for the DELIVER cycle.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    send_grant_d  = '0;
    recv_valid_d  = '0;
    src_id_d      = '0;
    instruction_d = '0;
    drop_err_d    = 1'b0;
    case (state_q)
      ARB: begin
        if (arb_any) begin
          state_d      = DELIVER;
          ptr_d        = arb_id;
          send_grant_d = arb_gnt;
          if (win_bcast) begin
            recv_valid_d  = ~arb_gnt;
            src_id_d      = arb_id;
            instruction_d = win_instr;
          end else if (win_dst_ok) begin
            recv_valid_d  = {{(NUM_CORES-1){1'b0}}, 1'b1} << win_dst;
            src_id_d      = arb_id;
            instruction_d = win_instr;
          end else begin
            drop_err_d = 1'b1;
          end
        end
      end
      DELIVER: state_d = RECOVER;
      RECOVER: state_d = ARB;
      default: state_d = ARB;
    endcase
    busy_d = (state_d != ARB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB;
      ptr_q         <= CORE_ID_WIDTH'(NUM_CORES - 1);
      send_grant_q  <= '0;
      recv_valid_q  <= '0;
      src_id_q      <= '0;
      instruction_q <= '0;
      busy_q        <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      send_grant_q  <= send_grant_d;
      recv_valid_q  <= recv_valid_d;
      src_id_q      <= src_id_d;
      instruction_q <= instruction_d;
      busy_q        <= busy_d;
      drop_err_q    <= drop_err_d;
    end
  end

  assign send_grant  = send_grant_q;
  assign recv_valid  = recv_valid_q;
  assign src_id      = src_id_q;
  assign instruction = instruction_q;
  assign busy        = busy_q;
  assign drop_err    = drop_err_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(send_grant));
  a_recv_needs_grant: assert property (@(posedge clk) disable iff (rst)
    (send_grant == '0) |-> (recv_valid == '0));
  // Neither unicast nor broadcast may ever loop back to the sender.
  a_no_self_delivery: assert property (@(posedge clk) disable iff (rst)
    (send_grant != '0) |-> !recv_valid[src_id]);

endmodule
